subr8s_pipe: RTL

SUBR8S_PIPE -- requirements
Module: subr8s_pipe

---
 rtl/subr8s_pipe_if.sv | 47 ++++
 rtl/subr8s_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/subr8s_pipe_if.sv
// Handshake bundle for subr8s_pipe: operand input channel, result output channel, check status.
// Latency: none, wires only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready; the producer side drives valid, the consumer side drives ready.
//
// Signals:
//   a, b        8-bit two's complement minuend / subtrahend
//   in_valid    a/b valid this cycle           in_ready  block accepts a/b this cycle
//   o           9-bit two's complement difference
//   out_valid   o valid                        out_ready consumer accepts o this cycle
//   err         duplicate-compute mismatch flag for the current o
//   err_cnt     saturating mismatch count
// Modports: master = environment (drives operands, out_ready); slave = the pipeline.
interface subr8s_pipe_if;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] o;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic [7:0] err_cnt;

    modport master (
        output a,
        output b,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  o,
        input  out_valid,
        input  err,
        input  err_cnt
    );

    modport slave (
        input  a,
        input  b,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output o,
        output out_valid,
        output err,
        output err_cnt
    );
endinterface

// File: rtl/subr8s_pipe.sv
// Two-stage 8-bit signed subtractor, o = sext9(a) - sext9(b), exact over -255..+255.
// Latency: 2 cycles from acceptance to out_valid when out_ready is held high; 1 result per cycle.
// Backpressure: out_ready low holds o/out_valid/err; in_ready drops only when both stages are full and stalled.
//
// Ports:
//   clk   single clock, all state on the rising edge
//   rst   synchronous active-high reset; clears both stages and the error state
//   bus   subr8s_pipe_if.slave: a, b, in_valid, in_ready, o, out_valid, out_ready, err, err_cnt
//
// Optional feature, macro SUBR8S_DUP_CHECK_EN:
//   defined   -> stage 2 recomputes the difference with an independent full-width subtractor
//                from the stage-1 operands; err flags a mismatch with o, err_cnt counts retired
//                mismatching results and saturates at 8'hFF.
//   undefined -> no duplicate logic; err and err_cnt are constant 0; timing identical.
module subr8s_pipe (
    input  logic         clk,
    input  logic         rst,
    subr8s_pipe_if.slave bus
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_vld_q, s1_vld_d;
    logic s2_vld_q, s2_vld_d;

    logic s2_adv;   // stage 2 may load this cycle (empty or being retired)
    logic s1_adv;   // stage 1 content moves into stage 2 this cycle
    logic in_rdy;
    logic in_fire;
    logic out_fire;

    always_comb begin
        s2_adv   = !s2_vld_q || bus.out_ready;
        s1_adv   = s1_vld_q && s2_adv;
        // Depends only on pipeline state and out_ready, never on in_valid.
        in_rdy   = !s1_vld_q || s2_adv;
        in_fire  = bus.in_valid && in_rdy;
        out_fire = s2_vld_q && bus.out_ready;
    end

    assign bus.in_ready = in_rdy;

    // ------------------------------------------------------------------
    // Stage 1: low-nibble difference with borrow, high nibbles carried
    // ------------------------------------------------------------------
    logic [4:0] s1_lo_q, s1_lo_d;     // [4] = borrow out of the low nibble, [3:0] = difference
    logic [3:0] s1_ahi_q, s1_ahi_d;
    logic [3:0] s1_bhi_q, s1_bhi_d;
    logic [4:0] lo_diff;

    // A 5-bit unsigned subtract of zero-extended nibbles leaves the borrow in bit 4.
    assign lo_diff = {1'b0, bus.a[3:0]} - {1'b0, bus.b[3:0]};

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_lo_d  = s1_lo_q;
        s1_ahi_d = s1_ahi_q;
        s1_bhi_d = s1_bhi_q;
        if (in_fire) begin
            // A new operand pair may land in the same cycle the old one moves on.
            s1_vld_d = 1'b1;
            s1_lo_d  = lo_diff;
            s1_ahi_d = bus.a[7:4];
            s1_bhi_d = bus.b[7:4];
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_lo_q  <= 5'h00;
            s1_ahi_q <= 4'h0;
            s1_bhi_q <= 4'h0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_lo_q  <= s1_lo_d;
            s1_ahi_q <= s1_ahi_d;
            s1_bhi_q <= s1_bhi_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: signed high part with borrow-in forms o[8:4]
    // ------------------------------------------------------------------
    logic [8:0] o_q, o_d;
    logic [4:0] hi_diff;
    logic [8:0] o_pri;

    // Value = 16*(ahi - bhi - borrow) + lo, with the high nibbles sign-extended to 5 bits;
    // 5 bits cover -16..+15, enough for the -16..+15 range this sum can take.
    assign hi_diff = {s1_ahi_q[3], s1_ahi_q} - {s1_bhi_q[3], s1_bhi_q} - {4'b0000, s1_lo_q[4]};
    assign o_pri   = {hi_diff, s1_lo_q[3:0]};

    always_comb begin
        s2_vld_d = s2_vld_q;
        o_d      = o_q;
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            // When stage 1 is empty, o keeps its last value rather than loading junk.
            if (s1_vld_q) begin
                o_d = o_pri;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            o_q      <= 9'h000;
        end else begin
            s2_vld_q <= s2_vld_d;
            o_q      <= o_d;
        end
    end

    assign bus.o         = o_q;
    assign bus.out_valid = s2_vld_q;

`ifdef SUBR8S_DUP_CHECK_EN
    // ------------------------------------------------------------------
    // Duplicate compute: the low operand nibbles are kept in stage 1 so
    // that a full 9-bit subtractor, sharing no logic with the split
    // primary path, can cross-check o.
    // ------------------------------------------------------------------
    logic [3:0] s1_alo_q, s1_alo_d;
    logic [3:0] s1_blo_q, s1_blo_d;
    logic [8:0] dup_diff;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        s1_alo_d = s1_alo_q;
        s1_blo_d = s1_blo_q;
        if (in_fire) begin
            s1_alo_d = bus.a[3:0];
            s1_blo_d = bus.b[3:0];
        end
    end

    assign dup_diff = {s1_ahi_q[3], s1_ahi_q, s1_alo_q} - {s1_bhi_q[3], s1_bhi_q, s1_blo_q};

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        // err travels with o, so it holds through a stall exactly like o.
        if (s2_adv) begin
            err_d = s1_vld_q && (dup_diff != o_pri);
        end
        // Count on retirement so a stalled result is counted only once.
        if (out_fire && err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_alo_q  <= 4'h0;
            s1_blo_q  <= 4'h0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            s1_alo_q  <= s1_alo_d;
            s1_blo_q  <= s1_blo_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
`else
    // out_fire only feeds the mismatch counter.
    logic unused_out_fire;
    assign unused_out_fire = out_fire;

    assign bus.err     = 1'b0;
    assign bus.err_cnt = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    // A stalled result must stay put until the consumer takes it.
    a_stall_hold: assert property (@(posedge clk)
        (!rst && bus.out_valid && !bus.out_ready) |=> (rst || (bus.out_valid && $stable(bus.o))));

    // With both stages full and the output stalled, nothing more may be accepted.
    a_full_blocks: assert property (@(posedge clk)
        (s1_vld_q && s2_vld_q && !bus.out_ready) |-> !bus.in_ready);

endmodule
